// File: rtl/program_loader.sv
// Framed byte-stream loader: SYNC, start address, length, payload (+ optional checksum)
// written into instruction memory while the CPU is halted. Checksum byte enabled by LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] SYNC_BYTE = 'hA5,
  parameter int                TIMEOUT   = 1024
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_in_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_data,
  output logic              o_cpu_halt,
  output logic              o_done,
  output logic              o_error
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_LEN  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_CSUM = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam int LEN_W = ADDR_W + 1;

  logic [2:0]        r_state;
  logic              r_in_ready;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_data;
  logic              r_halt;
  logic              r_done;
  logic              r_error;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_remain;
  logic [CNT_W-1:0]  r_cnt;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] r_csum;
  logic              r_csum_bad;
`endif

  logic              w_accept;
  logic              w_busy;
  logic              w_timeout;
  logic [ADDR_W-1:0] w_byte_addr;
  logic [LEN_W-1:0]  w_byte_len;

  assign w_accept    = i_in_valid & r_in_ready;
  assign w_busy      = (r_state == S_ADDR) || (r_state == S_LEN) ||
                       (r_state == S_DATA) || (r_state == S_CSUM);
  assign w_timeout   = w_busy && !w_accept && (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_byte_addr = ADDR_W'(i_in_data);
  // A length byte of zero encodes a full memory image.
  assign w_byte_len  = (w_byte_addr == '0) ? (LEN_W'(1) << ADDR_W) : {1'b0, w_byte_addr};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_halt     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_addr     <= '0;
      r_remain   <= '0;
      r_cnt      <= '0;
`ifdef LOADER_CHECKSUM_EN
      r_csum     <= '0;
      r_csum_bad <= 1'b0;
`endif
    end else begin
      r_mem_we   <= 1'b0;
      r_done     <= 1'b0;
      r_in_ready <= 1'b1;
      // Halt is released the cycle after the Done pulse; a new SYNC below overrides this.
      if (r_done)
        r_halt <= 1'b0;
      if (w_busy && !w_accept)
        r_cnt <= r_cnt + CNT_W'(1);
      else
        r_cnt <= '0;

      case (r_state)
        S_IDLE: begin
          if (w_accept && (i_in_data == SYNC_BYTE)) begin
            r_state <= S_ADDR;
            r_halt  <= 1'b1;
            r_error <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_csum     <= '0;
            r_csum_bad <= 1'b0;
`endif
          end
        end
        S_ADDR: begin
          if (w_accept) begin
            r_addr  <= w_byte_addr;
            r_state <= S_LEN;
          end
        end
        S_LEN: begin
          if (w_accept) begin
            r_remain <= w_byte_len;
            r_state  <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_mem_we   <= 1'b1;
            r_mem_addr <= r_addr;
            r_mem_data <= i_in_data;
            r_addr     <= r_addr + ADDR_W'(1);
            r_remain   <= r_remain - LEN_W'(1);
`ifdef LOADER_CHECKSUM_EN
            r_csum <= r_csum ^ i_in_data;
            if (r_remain == LEN_W'(1))
              r_state <= S_CSUM;
`else
            if (r_remain == LEN_W'(1)) begin
              r_state    <= S_DONE;
              r_in_ready <= 1'b0;
            end
`endif
          end
        end
        S_CSUM: begin
`ifdef LOADER_CHECKSUM_EN
          if (w_accept) begin
            r_csum_bad <= (i_in_data != r_csum);
            r_state    <= S_DONE;
            r_in_ready <= 1'b0;
          end
`else
          r_state <= S_IDLE;
`endif
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
          r_error <= r_error | r_csum_bad;
`endif
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_timeout) begin
        r_state <= S_IDLE;
        r_done  <= 1'b1;
        r_error <= 1'b1;
      end
    end
  end

  assign o_in_ready = r_in_ready;
  assign o_mem_we   = r_mem_we;
  assign o_mem_addr = r_mem_addr;
  assign o_mem_data = r_mem_data;
  assign o_cpu_halt = r_halt;
  assign o_done     = r_done;
  assign o_error    = r_error;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed and random frames, checked against
// per-cycle logs using frame-level expectations (write list, Done cycle, Error, Halt window).
module tb_program_loader;
  localparam int TIMEOUT = 1024;
  localparam int LOG     = 8192;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, mem_we, cpu_halt, done, error;
  logic [7:0] mem_addr, mem_data;

  program_loader #(.ADDR_W(8), .DATA_W(8), .SYNC_BYTE(8'hA5), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .i_in_data(in_data),
    .o_in_ready(in_ready), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_data(mem_data),
    .o_cpu_halt(cpu_halt), .o_done(done), .o_error(error)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges so far; log[k] holds the outputs registered at edge k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       we_a[LOG], halt_a[LOG], done_a[LOG], err_a[LOG], rdy_a[LOG];
  logic [7:0] addr_a[LOG], data_a[LOG];
  always @(negedge clk) begin
    if (cyc < LOG) begin
      we_a[cyc] = mem_we;  addr_a[cyc] = mem_addr; data_a[cyc] = mem_data;
      halt_a[cyc] = cpu_halt; done_a[cyc] = done; err_a[cyc] = error; rdy_a[cyc] = in_ready;
    end
  end

  int total = 0;
  int bad = 0;
  logic [7:0] pl[256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int count_we(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) if (i >= 0 && i < LOG && we_a[i] === 1'b1) n++;
    return n;
  endfunction

  function automatic int count_done(input int a, input int b);
    int n = 0;
    for (int i = a; i <= b; i++) if (i >= 0 && i < LOG && done_a[i] === 1'b1) n++;
    return n;
  endfunction

  // Present a byte at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] b, output int acc);
    int w = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (in_ready !== 1'b1) check("send_ready_wait", in_ready, 1);
    @(negedge clk);
    acc = cyc;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // One complete frame with payload pl[0..n-1]; verifies writes, Done, Error and Halt.
  task automatic do_frame(input string name, input logic [7:0] a, input int n,
                          input int max_gap, input bit corrupt, output int done_c);
    int sync_c, c, exp_done;
    int acc[256];
    logic [7:0] x, ea, len_b;
    logic exp_err;
    x = 8'h00;
    exp_err = 1'b0;
    len_b = 8'(n);
    send(8'hA5, sync_c);
    idle($urandom_range(max_gap, 0));
    send(a, c);
    idle($urandom_range(max_gap, 0));
    send(len_b, c);
    for (int i = 0; i < n; i++) begin
      idle($urandom_range(max_gap, 0));
      send(pl[i], acc[i]);
      x = x ^ pl[i];
    end
    exp_done = acc[n-1] + 1;
`ifdef LOADER_CHECKSUM_EN
    idle($urandom_range(max_gap, 0));
    send(corrupt ? (x ^ 8'(1 + $urandom_range(254, 0))) : x, c);
    exp_done = c + 1;
    exp_err  = corrupt;
`endif
    idle(4);
    for (int i = 0; i < n; i++) begin
      ea = a + 8'(i);
      check({name, "_we"}, we_a[acc[i]], 1);
      check({name, "_addr"}, addr_a[acc[i]], ea);
      check({name, "_data"}, data_a[acc[i]], pl[i]);
    end
    check({name, "_wr_count"}, count_we(sync_c, cyc - 1), n);
    check({name, "_done"}, done_a[exp_done], 1);
    check({name, "_done_count"}, count_done(sync_c, cyc - 1), 1);
    check({name, "_error"}, err_a[exp_done], exp_err);
    check({name, "_err_clr_on_sync"}, err_a[sync_c], 0);
    check({name, "_halt_start"}, halt_a[sync_c], 1);
    check({name, "_halt_at_done"}, halt_a[exp_done], 1);
    check({name, "_halt_end"}, halt_a[exp_done + 1], 0);
    check({name, "_ready_in_done"}, rdy_a[exp_done - 1], 0);
    $display("frame %s addr=%02h len=%0d done_cycle=%0d error=%0b", name, a, n, exp_done, err_a[exp_done]);
    done_c = exp_done;
  endtask

  initial begin
    int c, e, d, g0;
    logic [7:0] b;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", in_ready, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", mem_data, 0);
    check("rst_halt", cpu_halt, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", in_ready, 1);

    // Basic frame
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    do_frame("basic", 8'h10, 3, 0, 1'b0, d);

    // Address wrap
    pl[0] = 8'h01; pl[1] = 8'h02; pl[2] = 8'h03;
    do_frame("wrap", 8'hFE, 3, 0, 1'b0, d);

`ifdef LOADER_CHECKSUM_EN
    pl[0] = 8'h0F; pl[1] = 8'hF0;
    do_frame("csum_good", 8'h00, 2, 0, 1'b0, d);
    do_frame("csum_bad", 8'h00, 2, 0, 1'b1, d);
    check("csum_err_sticky", err_a[d + 2], 1);
    do_frame("csum_recover", 8'h00, 2, 0, 1'b0, d);
`endif

    // Timeout mid-frame
    send(8'hA5, g0); send(8'h00, c); send(8'h05, c); send(8'hAA, e);
    idle(TIMEOUT + 4);
    check("to_done", done_a[e + TIMEOUT], 1);
    check("to_done_count", count_done(g0, cyc - 1), 1);
    check("to_error", err_a[e + TIMEOUT], 1);
    check("to_wr_count", count_we(g0, cyc - 1), 1);
    check("to_wr_addr", addr_a[e], 8'h00);
    check("to_wr_data", data_a[e], 8'hAA);
    check("to_halt_at_done", halt_a[e + TIMEOUT], 1);
    check("to_halt_end", halt_a[e + TIMEOUT + 1], 0);
    check("to_ready_idle", rdy_a[e + TIMEOUT + 1], 1);
    $display("timeout frame: last byte cycle=%0d done_cycle=%0d", e, e + TIMEOUT);

    // Reset mid-frame after 2 of 4 payload bytes
    send(8'hA5, g0); send(8'h40, c); send(8'h04, c); send(8'h01, c); send(8'h02, e);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(6);
    check("mrst_we", we_a[e + 1], 0);
    check("mrst_halt", halt_a[e + 1], 0);
    check("mrst_done", done_a[e + 1], 0);
    check("mrst_error", err_a[e + 1], 0);
    check("mrst_ready", rdy_a[e + 1], 0);
    check("mrst_addr", addr_a[e + 1], 0);
    check("mrst_data", data_a[e + 1], 0);
    check("mrst_no_writes", count_we(e + 1, cyc - 1), 0);
    check("mrst_wr_before", count_we(g0, e), 2);
    $display("mid-frame reset at cycle %0d", e + 1);
    for (int i = 0; i < 4; i++) pl[i] = 8'(8'hC0 + i);
    do_frame("after_rst", 8'h40, 4, 0, 1'b0, d);

    // Random frames with leading garbage and gaps between bytes
    for (int f = 0; f < 6; f++) begin
      int ng = $urandom_range(2, 0);
      int n  = $urandom_range(24, 1);
      g0 = cyc;
      for (int k = 0; k < ng; k++) begin
        b = 8'($urandom_range(255, 0));
        if (b == 8'hA5) b = 8'h5A;
        send(b, c);
      end
      idle(2);
      check("rand_garbage_halt", halt_a[cyc - 1], 0);
      check("rand_garbage_we", count_we(g0, cyc - 1), 0);
      for (int i = 0; i < n; i++) pl[i] = 8'($urandom_range(255, 0));
      do_frame("rand", 8'($urandom_range(255, 0)), n, 3, 1'($urandom_range(1, 0)), d);
    end

    // Garbage then a full 256-byte image starting at 0x20
    g0 = cyc;
    send(8'h00, c); send(8'h13, c); send(8'hA4, c);
    idle(2);
    check("garbage_halt", halt_a[cyc - 1], 0);
    check("garbage_we", count_we(g0, cyc - 1), 0);
    for (int i = 0; i < 256; i++) pl[i] = 8'($urandom_range(255, 0));
    do_frame("full256", 8'h20, 256, 0, 1'b0, d);
    check("full256_total_writes", count_we(g0, cyc - 1), 256);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
